// File: rtl/countdown_timer_pkg.sv
// Shared types and helpers for the countdown timer: state encoding, widths,
// and load saturation.
package countdown_timer_pkg;

    localparam int unsigned SEC_W = 7;
    localparam int unsigned BCD_W = 4;
    localparam int unsigned ST_W  = 2;
    localparam int unsigned DISPLAY_MAX = 99;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    // Clamp a requested start value to the configured ceiling.
    function automatic logic [SEC_W-1:0] sat_seconds(
        input logic [SEC_W-1:0] value,
        input logic [SEC_W-1:0] ceiling
    );
        return (value > ceiling) ? ceiling : value;
    endfunction

endpackage

// File: rtl/countdown_timer_rising_edge_detector.sv
// Single-cycle pulse on each rising edge of a level sampled in the clock domain.
// During reset the history register tracks the input so release never fires.
module rising_edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= in;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign pulse = in & ~prev_q;

endmodule

// File: rtl/countdown_timer.sv
// Whole-second game countdown driven by ticks of the divided clock, with
// load/start/pause control, BCD display digits and expiry indications.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_SECOND = 1000,
    parameter int unsigned MAX_SECONDS      = 99
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clock_divised,
    input  logic             load,
    input  logic [SEC_W-1:0] load_seconds,
    input  logic             start,
    input  logic             pause,
    output logic [SEC_W-1:0] seconds,
    output logic [BCD_W-1:0] bcd_tens,
    output logic [BCD_W-1:0] bcd_units,
    output logic             running,
    output logic             expired,
    output logic             expired_pulse
);

    localparam int unsigned SUB_W   = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
    localparam int unsigned SEC_CAP = (MAX_SECONDS > DISPLAY_MAX) ? DISPLAY_MAX : MAX_SECONDS;
    localparam int unsigned SUB_TOP = (TICKS_PER_SECOND > 0) ? TICKS_PER_SECOND - 1 : 0;

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_TOP);
    localparam logic [SEC_W-1:0] SEC_MAX  = SEC_W'(SEC_CAP);
    localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);
    localparam logic [SEC_W-1:0] SEC_TEN  = SEC_W'(10);

    state_e           state_q,   state_d;
    logic [SEC_W-1:0] seconds_q, seconds_d;
    logic [SUB_W-1:0] sub_q,     sub_d;
    logic             pulse_q,   pulse_d;
    logic             tick;

    rising_edge_detector u_tick_det (
        .clock (clock),
        .reset (reset),
        .in    (clock_divised),
        .pulse (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            seconds_q <= '0;
            sub_q     <= '0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            seconds_q <= seconds_d;
            sub_q     <= sub_d;
            pulse_q   <= pulse_d;
        end
    end

    // Load overrides every state; otherwise the FSM advances on start/pause/tick.
    always_comb begin
        state_d   = state_q;
        seconds_d = seconds_q;
        sub_d     = sub_q;
        pulse_d   = 1'b0;

        if (load) begin
            seconds_d = sat_seconds(load_seconds, SEC_MAX);
            sub_d     = '0;
            state_d   = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = (seconds_q != '0) ? ST_RUNNING : ST_EXPIRED;
                    end
                end
                ST_RUNNING: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (tick) begin
                        if (sub_q == SUB_LAST) begin
                            sub_d = '0;
                            if (seconds_q <= SEC_ONE) begin
                                seconds_d = '0;
                                state_d   = ST_EXPIRED;
                            end else begin
                                seconds_d = seconds_q - SEC_ONE;
                            end
                        end else begin
                            sub_d = sub_q + SUB_W'(1);
                        end
                    end
                end
                ST_PAUSED: begin
                    if (start) begin
                        state_d = ST_RUNNING;
                    end
                end
                ST_EXPIRED: begin
                    seconds_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        pulse_d = (state_d == ST_EXPIRED) && (state_q != ST_EXPIRED);
    end

    assign seconds       = seconds_q;
    assign running       = (state_q == ST_RUNNING);
    assign expired       = (state_q == ST_EXPIRED);
    assign expired_pulse = pulse_q;

    // Display digits follow the registered count in the same cycle.
    assign bcd_tens  = BCD_W'(seconds_q / SEC_TEN);
    assign bcd_units = BCD_W'(seconds_q % SEC_TEN);

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized directed bench for countdown_timer against a remaining-ticks model.
module tb_countdown_timer;

    localparam int TPS        = 4;
    localparam int DIV_PERIOD = 10;
    localparam int DIV_HIGH   = 5;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PAUS = 2;
    localparam int M_EXP  = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       clock_divised;
    logic       load;
    logic [6:0] load_seconds;
    logic       start;
    logic       pause;
    logic [6:0] seconds;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_units;
    logic       running;
    logic       expired;
    logic       expired_pulse;

    int tests_run = 0;
    int failures  = 0;

    // Model: the remaining time counted in ticks; displayed seconds is its ceiling.
    int m_mode  = M_IDLE;
    int m_rem   = 0;
    int m_pulse = 0;
    bit m_prev  = 1'b0;
    int div_phase = 0;

    countdown_timer #(
        .TICKS_PER_SECOND (TPS),
        .MAX_SECONDS      (99)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .clock_divised (clock_divised),
        .load          (load),
        .load_seconds  (load_seconds),
        .start         (start),
        .pause         (pause),
        .seconds       (seconds),
        .bcd_tens      (bcd_tens),
        .bcd_units     (bcd_units),
        .running       (running),
        .expired       (expired),
        .expired_pulse (expired_pulse)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_secs();
        return (m_rem + TPS - 1) / TPS;
    endfunction

    task automatic check_all();
        int s;
        s = m_secs();
        check("seconds",       32'(seconds),       s);
        check("bcd_tens",      32'(bcd_tens),      s / 10);
        check("bcd_units",     32'(bcd_units),     s % 10);
        check("running",       32'(running),       (m_mode == M_RUN)  ? 1 : 0);
        check("expired",       32'(expired),       (m_mode == M_EXP)  ? 1 : 0);
        check("expired_pulse", 32'(expired_pulse), m_pulse);
    endtask

    task automatic model_step();
        bit tick;
        int old_mode;
        tick     = clock_divised && !m_prev;
        m_prev   = clock_divised;
        old_mode = m_mode;
        if (reset) begin
            m_mode = M_IDLE;
            m_rem  = 0;
        end else if (load) begin
            m_rem  = ((int'(load_seconds) > 99) ? 99 : int'(load_seconds)) * TPS;
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (start) m_mode = (m_rem > 0) ? M_RUN : M_EXP;
                M_RUN: begin
                    if (pause) m_mode = M_PAUS;
                    else if (tick) begin
                        m_rem--;
                        if (m_rem == 0) m_mode = M_EXP;
                    end
                end
                M_PAUS: if (start) m_mode = M_RUN;
                default: ;
            endcase
        end
        m_pulse = (!reset && m_mode == M_EXP && old_mode != M_EXP) ? 1 : 0;
    endtask

    // One system-clock cycle: drive the divided clock, advance model, then check.
    task automatic cyc();
        clock_divised = (div_phase < DIV_HIGH);
        div_phase     = (div_phase + 1) % DIV_PERIOD;
        model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic do_load(input int value);
        load = 1'b1;
        load_seconds = 7'(value);
        cyc();
        load = 1'b0;
        load_seconds = 7'($urandom_range(0, 127));
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic run_until_expired(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (m_mode == M_EXP) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, 32'(expired), 32'(done));
    endtask

    initial begin
        int s_held;
        int ticks;
        bit found;

        reset = 1'b1;
        load = 1'b0;
        load_seconds = '0;
        start = 1'b0;
        pause = 1'b0;
        clock_divised = 1'b1;

        // Reset while the divided clock is high; release inside the high phase.
        div_phase = 0;
        repeat (3) cyc();
        reset = 1'b0;
        repeat (12) cyc();
        check("s1_idle_seconds", 32'(seconds), 0);

        // Full countdown from 3, then a few random short ones.
        do_load(3);
        check("s2_loaded_units", 32'(bcd_units), 3);
        do_start();
        check("s2_running", 32'(running), 1);
        run_until_expired("s2_reached_expiry", 400);
        check("s2_pulse_first", 32'(expired_pulse), 1);
        cyc();
        check("s2_pulse_gone", 32'(expired_pulse), 0);
        repeat (3) begin
            do_load($urandom_range(1, 6));
            repeat ($urandom_range(0, 7)) cyc();
            do_start();
            run_until_expired("s2r_reached_expiry", 1000);
            repeat (3) cyc();
        end

        // Saturating load and zero-second start.
        do_load($urandom_range(100, 127));
        check("s3_sat_tens", 32'(bcd_tens), 9);
        check("s3_sat_units", 32'(bcd_units), 9);
        do_load(0);
        do_start();
        check("s3_zero_expired", 32'(expired), 1);
        check("s3_zero_pulse", 32'(expired_pulse), 1);
        repeat (4) cyc();

        // Pause coinciding with a tick at sub-second count 2.
        do_load($urandom_range(3, 9));
        do_start();
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (div_phase == 0 && m_mode == M_RUN && (m_rem % TPS) == 2) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        check("s4_align_found", 32'(running), 32'(found));
        s_held = m_secs();
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        check("s4_paused", 32'(running), 0);
        repeat (200) cyc();
        check("s4_held_seconds", 32'(seconds), s_held);
        do_start();
        ticks = 0;
        for (int i = 0; i < 200; i++) begin
            if (clock_divised == 1'b0 && div_phase == 0) ticks++;
            cyc();
            if (int'(seconds) != s_held) break;
        end
        check("s4_ticks_to_decrement", ticks, 2);

        // EXPIRED ignores start/pause; load mid-count returns to IDLE.
        do_load(0);
        do_start();
        for (int i = 0; i < 50; i++) begin
            start = 1'($urandom_range(0, 1));
            pause = 1'($urandom_range(0, 1));
            cyc();
        end
        start = 1'b0;
        pause = 1'b0;
        check("s5_still_expired", 32'(expired), 1);
        do_load(8);
        do_start();
        repeat ($urandom_range(15, 35)) cyc();
        do_load(5);
        check("s5_reload_seconds", 32'(seconds), 5);
        check("s5_reload_idle", 32'(running), 0);
        do_start();
        run_until_expired("s5_reached_expiry", 1000);

        // Reset mid-count at seven seconds.
        do_load(9);
        do_start();
        for (int i = 0; i < 400; i++) begin
            if (m_secs() == 7 && (m_rem % TPS) != 0) break;
            cyc();
        end
        check("s6_at_seven", 32'(seconds), 7);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("s6_reset_seconds", 32'(seconds), 0);
        repeat (30) cyc();

        // Free-running random control traffic.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            load  = ($urandom_range(0, 59) == 0);
            load_seconds = 7'($urandom_range(0, 127));
            start = ($urandom_range(0, 9) == 0);
            pause = ($urandom_range(0, 14) == 0);
            cyc();
        end
        reset = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
